// File: rtl/pipe_skid_reg_pkg.sv
// rtl/pipe_skid_reg_pkg.sv - shared state encoding and default word width for pipe_skid_reg
package pipe_skid_reg_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Occupancy is read straight off the state encoding.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry elastic pipeline register with registered in_ready
// Optional synchronous flush enabled by defining PIPE_FLUSH_EN.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_accept;
  logic             w_pop;
  logic             w_flush;
  logic             w_load_main_in;
  logic             w_load_main_skid;
  logic             w_load_skid;

`ifdef PIPE_FLUSH_EN
  assign w_flush = flush;
`else
  logic w_unused_flush;
  assign w_unused_flush = flush;
  assign w_flush        = 1'b0;
`endif

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main;
  assign occupancy = r_state;

  assign w_accept = in_valid & in_ready;
  assign w_pop    = out_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = ONE;
          w_load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_pop) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = FULL;
          w_load_skid = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_pop) begin
          w_state_nxt      = ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    // Flush outranks accept and pop and leaves the data registers untouched.
    if (w_flush) begin
      w_state_nxt      = EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= in_data;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Elastic two-entry pipeline register between multicycle datapath stages.
- The existing stage latch captures every cycle and ignores the consumer. This block is the consumer-facing end: it holds data under downstream backpressure and forwards data on a valid/ready handshake.
- Sits between producer and consumer stages, e.g. the ALU result feeding the memory/writeback stage.
- Full throughput of one word per cycle. in_ready is registered, so there is no combinational path from out_ready to in_ready.

Parameters:
- WIDTH, 32, data word width in bits.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has data on in_data.
- in_ready  out  1  block can accept this cycle; derived from registered state only.
- in_data  in  WIDTH  producer data.
- flush  in  1  synchronous discard of all held data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer takes out_data this cycle.
- out_data  out  WIDTH  oldest held word.
- occupancy  out  2  number of held words, 0..2.

Behaviour:
- Clocking and reset: one clock (CLK). Reset RST is asynchronous and active-high.
- Handshake terms:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register.
- FSM states: EMPTY (occupancy 0), ONE (1), FULL (2).
- Outputs by state:
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
- Reset (async, RST=1): state EMPTY, main=0, skid=0. Outputs: out_valid=0, in_ready=1, occupancy=0, out_data=0. Normal operation resumes on the first posedge after RST deasserts.
- Transitions at posedge, flush inactive:
  - EMPTY, accept -> ONE, main<=in_data.
  - EMPTY, no accept -> EMPTY.
  - ONE, accept & pop -> ONE, main<=in_data.
  - ONE, accept & !pop -> FULL, skid<=in_data.
  - ONE, !accept & pop -> EMPTY.
  - ONE, neither -> ONE.
  - FULL, pop -> ONE, main<=skid. (No accept is possible in FULL.)
  - FULL, no pop -> FULL.
- Latency: a word accepted at edge N is on out_data with out_valid=1 after edge N. Back-to-back streaming at 1 word/cycle with out_ready held high.
- Ordering: strict FIFO; no word is ever duplicated or dropped except by flush.
- Stability: while out_valid=1 and out_ready=0, out_data is unchanged.
- Simultaneous accept+pop in ONE: the new word replaces main in the same edge and state stays ONE.
- in_valid while FULL: ignored, no accept; the producer must hold its data.
- out_ready while EMPTY: ignored.
- Skid register contents are don't-care when state != FULL. They are cleared only by reset.
- Reset mid-transfer: all held words are lost immediately (async).

Optional Feature:
- Macro: PIPE_FLUSH_EN.
- Defined:
  - flush=1 at posedge forces state EMPTY, highest priority over accept and pop.
  - A word presented with accept in the same cycle is discarded.
  - The consumer sees out_valid=0 after the edge.
  - main and skid values are left as-is.
- Undefined: the flush port exists but is ignored; no flush logic is synthesized.

Decomposition:
- Shared package:
  - State encoding constants: EMPTY=2'd0, ONE=2'd1, FULL=2'd2. occupancy equals the state encoding.
  - Default WIDTH=32 constant, shared with the existing stage latches.
- Sub-modules: none. Single module; the FSM and two data registers are small enough to stay flat.

Test Plan:
- Reset: assert RST asynchronously mid-cycle with state FULL -> out_valid=0, in_ready=1, occupancy=0, out_data=0 immediately, before the next edge.
- Stream: out_ready=1, in_valid=1 with data 0x11,0x22,0x33 on consecutive edges -> out_data shows 0x11,0x22,0x33 one cycle later each; in_ready stays 1; occupancy stays 1.
- Backpressure: out_ready=0, push 0xAAAA0001 then 0xAAAA0002:
  - occupancy 1 then 2; in_ready=0 after the second edge.
  - Present 0xDEAD with in_valid=1 while FULL -> not accepted.
  - Release out_ready -> out_data 0xAAAA0001, then 0xAAAA0002; 0xDEAD never appears.
- Simultaneous: state ONE holding 0x5, accept 0x6 and pop in the same cycle -> state ONE, out_data=0x6, 0x5 consumed exactly once.
- Flush (PIPE_FLUSH_EN defined): state FULL, flush=1 with in_valid=1 (data 0x77) -> next cycle out_valid=0, occupancy=0, in_ready=1; 0x77 never appears at the output.
- Flush ignored (PIPE_FLUSH_EN undefined): same stimulus -> state stays FULL; contents drain in order once out_ready=1.
